ebpc_enc_arbiter: RTL and testbench
===================================

Name: ebpc_enc_arbiter

Overview:
Shares one ebpc_encoder instance between N_REQ independent input streams. Streams are arbitrated round-robin at stream granularity. A grant is held from the first word of a stream until that stream's last word has been accepted and the encoder reports idle. The block sits directly in front of the encoder's data_i/last_i/vld_i/rdy_o/idle_o interface. It publishes the active stream ID so downstream logic can tag ZNZ/BPC output, and reports per-stream completion with a word count.

Parameters:
N_REQ, 4, number of requesting streams (>=1)
CNT_W, 16, width of the per-stream accepted-word counter
(DATA_W comes from ebpc_pkg; IDW = max(1, $clog2(N_REQ)))

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; synchronous, active-low
en_mask_i  in  N_REQ  per-requester enable; sampled only during arbitration
req_data_i  in  N_REQ x DATA_W  requester data
req_last_i  in  N_REQ  requester last-word flag
req_vld_i  in  N_REQ  requester valid
req_rdy_o  out  N_REQ  requester ready
enc_data_o  out  DATA_W  to encoder data_i
enc_last_o  out  1  to encoder last_i
enc_vld_o  out  1  to encoder vld_i
enc_rdy_i  in  1  from encoder rdy_o
enc_idle_i  in  1  from encoder idle_o
busy_o  out  1  high in GRANT or DRAIN
cur_id_o  out  IDW  granted requester index; valid while busy_o
done_o  out  1  one-cycle pulse when a stream completes
done_id_o  out  IDW  ID of the completed stream; valid with done_o
done_cnt_o  out  CNT_W  words accepted for that stream; valid with done_o

Behaviour:
- Reset (synchronous, rst_ni=0 at a clk_i edge):
  - state=IDLE, rr_ptr=0, grant=0, count=0.
  - All req_rdy_o, enc_vld_o, enc_last_o, busy_o and done_o are 0; enc_data_o, cur_id_o, done_id_o and done_cnt_o are 0.
  - Reset mid-stream abandons the stream with no done_o pulse. The encoder must share rst_ni.
- States: IDLE, GRANT, DRAIN.
- IDLE:
  - req_rdy_o=0, enc_vld_o=0.
  - Candidates = req_vld_i & en_mask_i.
  - If candidates != 0 and enc_idle_i=1: winner = first candidate at or after rr_ptr (wrapping modulo N_REQ); register grant=winner, count=0, go to GRANT.
  - Arbitration latency is 1 cycle; no word is accepted in the arbitration cycle.
- GRANT:
  - enc_data_o=req_data_i[grant], enc_last_o=req_last_i[grant], enc_vld_o=req_vld_i[grant].
  - req_rdy_o[grant]=enc_rdy_i; all other req_rdy_o bits are 0. The ready path is combinational pass-through with no buffering.
  - Each handshake (vld & rdy) increments count, saturating at 2^CNT_W-1.
  - A handshake with req_last_i[grant]=1 moves to DRAIN.
  - en_mask_i changes during GRANT have no effect.
- DRAIN:
  - enc_vld_o=0, req_rdy_o=0.
  - The first DRAIN cycle ignores enc_idle_i, because the encoder may still show idle in the cycle that accepted the last word.
  - From the second cycle on, when enc_idle_i=1: pulse done_o for one cycle with done_id_o=grant and done_cnt_o=count. In the same cycle set rr_ptr=(grant+1) mod N_REQ and go to IDLE.
- IDLE is entered only with the encoder idle, so back-to-back streams are separated by at least 3 cycles.
- Simultaneous requests are resolved by rr_ptr only; a requester that deasserts req_vld_i before being granted simply loses its turn.
- N_REQ=1: the arbiter degenerates to a stream gate with the same timing.
- busy_o = (state != IDLE). cur_id_o holds grant until the IDLE entry.

Decomposition:
- ebpc_pkg gains:
  - typedef arb_state_t {ARB_IDLE, ARB_GRANT, ARB_DRAIN}
  - the IDW helper function.
- One sub-module, ebpc_rr_pick: a combinational round-robin picker with inputs req vector and ptr, outputs idx and any.

Test Plan:
- N_REQ=4, mask=4'b1111, only req 2 sends a 5-word stream (last on word 5) -> grant=2 one cycle after vld; 5 handshakes; done_o with done_id_o=2, done_cnt_o=5; rr_ptr=3.
- All four requesters valid continuously, each sending 3-word streams -> grant order 0,1,2,3,0; every done_cnt_o=3; no overlap of req_rdy_o bits.
- enc_rdy_i toggling 1,0,0,1 during GRANT -> count increments only on rdy cycles; req_rdy_o of non-granted requesters stays 0.
- Last word accepted while enc_idle_i is stuck high for 1 cycle, then low for 10 cycles, then high -> done_o fires exactly once, on the first idle cycle after the low period.
- mask=4'b1011 with req 2 valid and rr_ptr=2 -> req 3 granted; clearing mask bit 3 mid-GRANT -> stream still completes.
- rst_ni=0 for one cycle in the middle of a stream -> next cycle all outputs are 0, state IDLE, no done_o, and the next arbitration starts from req 0.

Source files
------------

// File: rtl/ebpc_pkg.sv
// Shared types and helpers for the EBPC encoder front-end blocks.
package ebpc_pkg;

   // Width of one encoder input word.
   localparam int unsigned DATA_W = 16;

   // Stream arbiter states: waiting for a request, passing a stream, waiting for the encoder to finish.
   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_GRANT,
      ARB_DRAIN
   } arb_state_t;

   // Index width for n requesters; a single requester still gets a 1-bit index.
   function automatic int unsigned idw(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ebpc_rr_pick.sv
// Combinational round-robin picker: first set bit of req_i at or after ptr_i, wrapping modulo N.
module ebpc_rr_pick
   import ebpc_pkg::*;
#(
   parameter  int unsigned N   = 4,
   localparam int unsigned IDW = idw(N)
) (
   input  logic [N-1:0]   req_i,
   input  logic [IDW-1:0] ptr_i,
   output logic [IDW-1:0] idx_o,
   output logic           any_o
);

   // off_idx[k] is the requester index that sits k places after the pointer.
   logic [N-1:0][IDW-1:0] off_idx;
   logic [N-1:0]          off_req;

   for (genvar gi = 0; gi < N; gi++) begin : g_off
      logic [IDW:0] sum;
      // ptr_i is always below N, so a single conditional subtract performs the wrap.
      assign sum          = {1'b0, ptr_i} + (IDW+1)'(gi);
      assign off_idx[gi]  = (sum >= (IDW+1)'(N)) ? IDW'(sum - (IDW+1)'(N)) : sum[IDW-1:0];
      assign off_req[gi]  = req_i[off_idx[gi]];
   end

   // Scan from the farthest offset down so the nearest requester overwrites and wins.
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (off_req[k]) begin
            idx_o = off_idx[k];
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ebpc_enc_arbiter.sv
// Shares one EBPC encoder between N_REQ streams, granting whole streams in round-robin order.
module ebpc_enc_arbiter
   import ebpc_pkg::*;
#(
   parameter  int unsigned N_REQ = 4,
   parameter  int unsigned CNT_W = 16,
   localparam int unsigned IDW   = idw(N_REQ)
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [N_REQ-1:0]              en_mask_i,
   input  logic [N_REQ-1:0][DATA_W-1:0]  req_data_i,
   input  logic [N_REQ-1:0]              req_last_i,
   input  logic [N_REQ-1:0]              req_vld_i,
   output logic [N_REQ-1:0]              req_rdy_o,
   output logic [DATA_W-1:0]             enc_data_o,
   output logic                          enc_last_o,
   output logic                          enc_vld_o,
   input  logic                          enc_rdy_i,
   input  logic                          enc_idle_i,
   output logic                          busy_o,
   output logic [IDW-1:0]                cur_id_o,
   output logic                          done_o,
   output logic [IDW-1:0]                done_id_o,
   output logic [CNT_W-1:0]              done_cnt_o
);

   arb_state_t       state_q;
   logic [IDW-1:0]   rr_ptr_q;
   logic [IDW-1:0]   grant_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             drain_first_q;

   logic [N_REQ-1:0] cand;
   logic [IDW-1:0]   pick_idx;
   logic             pick_any;
   logic             hs;
   logic             finish;
   logic [IDW-1:0]   rr_ptr_d;

   // Only enabled, valid requesters compete; the mask matters only while arbitrating.
   assign cand = req_vld_i & en_mask_i;

   ebpc_rr_pick #(
      .N (N_REQ)
   ) u_pick (
      .req_i (cand),
      .ptr_i (rr_ptr_q),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   assign hs       = (state_q == ARB_GRANT) && req_vld_i[grant_q] && enc_rdy_i;
   // The first drain cycle may still see the encoder idle from before it took the last word.
   assign finish   = (state_q == ARB_DRAIN) && !drain_first_q && enc_idle_i;
   assign count_d  = (count_q == '1) ? count_q : count_q + 1'b1;
   assign rr_ptr_d = (grant_q == IDW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

   // Pass the granted requester straight through to the encoder; no buffering on the ready path.
   always_comb begin
      req_rdy_o  = '0;
      enc_data_o = '0;
      enc_last_o = 1'b0;
      enc_vld_o  = 1'b0;
      if (state_q == ARB_GRANT) begin
         enc_data_o         = req_data_i[grant_q];
         enc_last_o         = req_last_i[grant_q];
         enc_vld_o          = req_vld_i[grant_q];
         req_rdy_o[grant_q] = enc_rdy_i;
      end
   end

   assign busy_o     = (state_q != ARB_IDLE);
   assign cur_id_o   = grant_q;
   assign done_o     = finish;
   assign done_id_o  = finish ? grant_q : '0;
   assign done_cnt_o = finish ? count_q : '0;

   // Arbitration FSM: pick a stream, count its accepted words, wait for the encoder to drain.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q       <= ARB_IDLE;
         rr_ptr_q      <= '0;
         grant_q       <= '0;
         count_q       <= '0;
         drain_first_q <= 1'b0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (pick_any && enc_idle_i) begin
                  grant_q <= pick_idx;
                  count_q <= '0;
                  state_q <= ARB_GRANT;
               end
            end
            ARB_GRANT: begin
               if (hs) begin
                  count_q <= count_d;
                  if (req_last_i[grant_q]) begin
                     state_q       <= ARB_DRAIN;
                     drain_first_q <= 1'b1;
                  end
               end
            end
            ARB_DRAIN: begin
               drain_first_q <= 1'b0;
               if (finish) begin
                  rr_ptr_q <= rr_ptr_d;
                  state_q  <= ARB_IDLE;
               end
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ebpc_enc_arbiter.sv
// Testbench for ebpc_enc_arbiter: requester stream model plus a completion scoreboard.
module tb_ebpc_enc_arbiter;
   import ebpc_pkg::*;

   localparam int N   = 4;
   localparam int IDW = 2;
   localparam int CW  = 16;

   logic                      clk_i = 1'b0;
   logic                      rst_ni;
   logic [N-1:0]              en_mask_i;
   logic [N-1:0][DATA_W-1:0]  req_data_i;
   logic [N-1:0]              req_last_i;
   logic [N-1:0]              req_vld_i;
   logic [N-1:0]              req_rdy_o;
   logic [DATA_W-1:0]         enc_data_o;
   logic                      enc_last_o;
   logic                      enc_vld_o;
   logic                      enc_rdy_i;
   logic                      enc_idle_i;
   logic                      busy_o;
   logic [IDW-1:0]            cur_id_o;
   logic                      done_o;
   logic [IDW-1:0]            done_id_o;
   logic [CW-1:0]             done_cnt_o;

   ebpc_enc_arbiter #(.N_REQ(N), .CNT_W(CW)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .en_mask_i  (en_mask_i),
      .req_data_i (req_data_i),
      .req_last_i (req_last_i),
      .req_vld_i  (req_vld_i),
      .req_rdy_o  (req_rdy_o),
      .enc_data_o (enc_data_o),
      .enc_last_o (enc_last_o),
      .enc_vld_o  (enc_vld_o),
      .enc_rdy_i  (enc_rdy_i),
      .enc_idle_i (enc_idle_i),
      .busy_o     (busy_o),
      .cur_id_o   (cur_id_o),
      .done_o     (done_o),
      .done_id_o  (done_id_o),
      .done_cnt_o (done_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Requester model: each requester plays rq_left streams of rq_len words.
   int rq_len [N];
   int rq_pos [N];
   int rq_left[N];
   int rq_sn  [N];
   logic [N-1:0] adv;

   typedef struct { int id; int cnt; } exp_t;
   exp_t exp_q[$];

   int cmp_cnt = 0;
   int err_cnt = 0;

   function automatic logic [DATA_W-1:0] word_of(input int i, input int sn, input int pos);
      return DATA_W'((i << 12) | ((sn & 15) << 8) | (pos & 255));
   endfunction

   always_comb begin
      req_vld_i  = '0;
      req_last_i = '0;
      req_data_i = '0;
      for (int i = 0; i < N; i++) begin
         if (rq_left[i] > 0) begin
            req_vld_i[i]  = 1'b1;
            req_last_i[i] = (rq_pos[i] == rq_len[i] - 1);
            req_data_i[i] = word_of(i, rq_sn[i], rq_pos[i]);
         end
      end
   end

   task automatic start_stream(input int id, input int len, input int nstreams);
      rq_len[id]  = len;
      rq_pos[id]  = 0;
      rq_sn[id]   = 0;
      rq_left[id] = nstreams;
   endtask

   task automatic push_exp(input int id, input int cnt);
      exp_t e;
      e.id  = id;
      e.cnt = cnt;
      exp_q.push_back(e);
   endtask

   // One clock cycle: observe outputs on the falling edge, then advance the requester model.
   task automatic step();
      exp_t e;
      int   id;
      @(negedge clk_i);
      adv = req_vld_i & req_rdy_o;
      if (req_rdy_o != '0) begin
         cmp_cnt++;
         if (!$onehot(req_rdy_o) || (exp_q.size() > 0 && req_rdy_o != (N'(1) << exp_q[0].id))) begin
            err_cnt++;
            $display("FAIL rdy_onehot: req_rdy_o=%b expected single bit for id %0d", req_rdy_o,
                     (exp_q.size() > 0) ? exp_q[0].id : -1);
         end
      end
      if (enc_vld_o && enc_rdy_i && exp_q.size() > 0) begin
         id = exp_q[0].id;
         cmp_cnt++;
         if (enc_data_o !== word_of(id, rq_sn[id], rq_pos[id]) ||
             enc_last_o !== (rq_pos[id] == rq_len[id] - 1)) begin
            err_cnt++;
            $display("FAIL enc_word: data=%h last=%b expected data=%h last=%b", enc_data_o, enc_last_o,
                     word_of(id, rq_sn[id], rq_pos[id]), (rq_pos[id] == rq_len[id] - 1));
         end
      end
      if (done_o) begin
         cmp_cnt++;
         if (exp_q.size() == 0) begin
            err_cnt++;
            $display("FAIL done_unexpected: done_id=%0d done_cnt=%0d expected no completion", done_id_o, done_cnt_o);
         end else begin
            e = exp_q.pop_front();
            if (int'(done_id_o) != e.id || int'(done_cnt_o) != e.cnt) begin
               err_cnt++;
               $display("FAIL done: id=%0d cnt=%0d expected id=%0d cnt=%0d", done_id_o, done_cnt_o, e.id, e.cnt);
            end else begin
               $display("done id=%0d cnt=%0d", done_id_o, done_cnt_o);
            end
         end
      end
      @(posedge clk_i);
      #1;
      for (int i = 0; i < N; i++) begin
         if (adv[i]) begin
            if (rq_pos[i] == rq_len[i] - 1) begin
               rq_pos[i]  = 0;
               rq_sn[i]   = rq_sn[i] + 1;
               rq_left[i] = rq_left[i] - 1;
            end else begin
               rq_pos[i] = rq_pos[i] + 1;
            end
         end
      end
   endtask

   task automatic wait_done(input string name, input int budget);
      for (int k = 0; k < budget; k++) begin
         if (exp_q.size() == 0) break;
         step();
      end
      if (exp_q.size() != 0) begin
         cmp_cnt++;
         err_cnt++;
         $display("FAIL %s_timeout: %0d completions outstanding expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_all_zero(input string name);
      cmp_cnt++;
      if (req_rdy_o !== '0 || enc_vld_o !== 1'b0 || enc_last_o !== 1'b0 || enc_data_o !== '0 ||
          busy_o !== 1'b0 || cur_id_o !== '0 || done_o !== 1'b0 || done_id_o !== '0 || done_cnt_o !== '0) begin
         err_cnt++;
         $display("FAIL %s: rdy=%b vld=%b last=%b data=%h busy=%b cur=%0d done=%b did=%0d dcnt=%0d expected all 0",
                  name, req_rdy_o, enc_vld_o, enc_last_o, enc_data_o, busy_o, cur_id_o, done_o, done_id_o, done_cnt_o);
      end
   endtask

   task automatic test_reset();
      rst_ni     = 1'b0;
      en_mask_i  = '1;
      enc_rdy_i  = 1'b1;
      enc_idle_i = 1'b1;
      for (int i = 0; i < N; i++) begin
         rq_len[i] = 1; rq_pos[i] = 0; rq_left[i] = 0; rq_sn[i] = 0;
      end
      start_stream(0, 3, 1);
      for (int k = 0; k < 3; k++) step();
      #3;
      check_all_zero("reset_outputs");
      step();
      rq_left[0] = 0;
      rst_ni     = 1'b1;
      step();
      #3;
      check_all_zero("post_reset_idle");
   endtask

   task automatic test_single();
      step();
      start_stream(2, 5, 1);
      push_exp(2, 5);
      #3;
      cmp_cnt++;
      if (busy_o !== 1'b0 || req_rdy_o !== '0) begin
         err_cnt++;
         $display("FAIL single_arb_cycle: busy=%b rdy=%b expected busy=0 rdy=0000", busy_o, req_rdy_o);
      end
      step();
      #3;
      cmp_cnt++;
      if (busy_o !== 1'b1 || cur_id_o !== 2'd2 || enc_vld_o !== 1'b1) begin
         err_cnt++;
         $display("FAIL single_grant: busy=%b cur=%0d vld=%b expected busy=1 cur=2 vld=1", busy_o, cur_id_o, enc_vld_o);
      end
      wait_done("single", 40);
      // Pointer now 3: with 1 and 3 both asking, 3 must go first.
      step();
      start_stream(1, 2, 1);
      start_stream(3, 2, 1);
      push_exp(3, 2);
      push_exp(1, 2);
      wait_done("rr_ptr_after_single", 60);
   endtask

   task automatic test_round_robin();
      step();
      rst_ni = 1'b0;
      step();
      rst_ni = 1'b1;
      start_stream(0, 3, 2);
      start_stream(1, 3, 1);
      start_stream(2, 3, 1);
      start_stream(3, 3, 1);
      push_exp(0, 3);
      push_exp(1, 3);
      push_exp(2, 3);
      push_exp(3, 3);
      push_exp(0, 3);
      wait_done("round_robin", 200);
   endtask

   task automatic test_rdy_toggle();
      logic pat[4];
      int   hs_seen;
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      hs_seen = 0;
      step();
      start_stream(1, 4, 1);
      push_exp(1, 4);
      for (int k = 0; k < 60; k++) begin
         step();
         enc_rdy_i = pat[k % 4];
         #3;
         if (!enc_rdy_i && busy_o) begin
            cmp_cnt++;
            if (req_rdy_o !== '0) begin
               err_cnt++;
               $display("FAIL rdy_low_gate: req_rdy_o=%b expected 0000", req_rdy_o);
            end
         end
         if (enc_vld_o && enc_rdy_i) hs_seen++;
         if (exp_q.size() == 0) break;
      end
      enc_rdy_i = 1'b1;
      wait_done("rdy_toggle", 10);
      cmp_cnt++;
      if (hs_seen != 4) begin
         err_cnt++;
         $display("FAIL rdy_toggle_hs: handshakes=%0d expected 4", hs_seen);
      end
   endtask

   task automatic test_idle_hold();
      bit seen_last;
      seen_last = 1'b0;
      step();
      start_stream(2, 2, 1);
      push_exp(2, 2);
      for (int k = 0; k < 20; k++) begin
         step();
         #3;
         if (enc_vld_o && enc_rdy_i && enc_last_o) begin
            seen_last = 1'b1;
            break;
         end
      end
      cmp_cnt++;
      if (!seen_last) begin
         err_cnt++;
         $display("FAIL idle_hold_last: last handshake seen=0 expected 1");
      end
      step();
      #3;
      cmp_cnt++;
      if (done_o !== 1'b0 || busy_o !== 1'b1) begin
         err_cnt++;
         $display("FAIL idle_hold_first_drain: done=%b busy=%b expected done=0 busy=1", done_o, busy_o);
      end
      for (int k = 0; k < 10; k++) begin
         step();
         enc_idle_i = 1'b0;
         #3;
         cmp_cnt++;
         if (done_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL idle_hold_low: done=%b expected 0 at low cycle %0d", done_o, k);
         end
      end
      step();
      enc_idle_i = 1'b1;
      #3;
      cmp_cnt++;
      if (done_o !== 1'b1 || done_id_o !== 2'd2 || done_cnt_o !== 16'd2) begin
         err_cnt++;
         $display("FAIL idle_hold_done: done=%b id=%0d cnt=%0d expected done=1 id=2 cnt=2", done_o, done_id_o, done_cnt_o);
      end
      step();
      #3;
      cmp_cnt++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
         err_cnt++;
         $display("FAIL idle_hold_after: done=%b busy=%b expected done=0 busy=0", done_o, busy_o);
      end
   endtask

   task automatic test_mask();
      // Pointer is 3; a lone stream on 1 moves it to 2.
      step();
      start_stream(1, 2, 1);
      push_exp(1, 2);
      wait_done("mask_setup", 40);
      step();
      en_mask_i = 4'b1011;
      start_stream(2, 3, 1);
      start_stream(3, 4, 1);
      push_exp(3, 4);
      for (int k = 0; k < 10; k++) begin
         step();
         #3;
         if (busy_o) break;
      end
      cmp_cnt++;
      if (busy_o !== 1'b1 || cur_id_o !== 2'd3) begin
         err_cnt++;
         $display("FAIL mask_grant: busy=%b cur=%0d expected busy=1 cur=3", busy_o, cur_id_o);
      end
      step();
      en_mask_i = 4'b0011;
      wait_done("mask_midgrant", 60);
      for (int k = 0; k < 4; k++) step();
      #3;
      cmp_cnt++;
      if (busy_o !== 1'b0) begin
         err_cnt++;
         $display("FAIL mask_blocked: busy=%b expected 0 with requester 2 masked", busy_o);
      end
      step();
      en_mask_i = 4'b1111;
      push_exp(2, 3);
      wait_done("mask_release", 60);
   endtask

   task automatic test_reset_mid();
      int hs_seen;
      hs_seen = 0;
      step();
      start_stream(1, 6, 1);
      for (int k = 0; k < 20; k++) begin
         step();
         #3;
         if (enc_vld_o && enc_rdy_i) hs_seen++;
         if (hs_seen == 2) break;
      end
      cmp_cnt++;
      if (hs_seen != 2) begin
         err_cnt++;
         $display("FAIL reset_mid_setup: handshakes=%0d expected 2", hs_seen);
      end
      step();
      rst_ni     = 1'b0;
      rq_left[1] = 0;
      step();
      rst_ni = 1'b1;
      #3;
      check_all_zero("reset_mid_outputs");
      // Pointer was 3 before the reset; after it, requester 0 must win over 3.
      start_stream(0, 2, 1);
      start_stream(3, 2, 1);
      push_exp(0, 2);
      push_exp(3, 2);
      wait_done("reset_mid_rearb", 60);
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_rdy_toggle();
      test_idle_hold();
      test_mask();
      test_reset_mid();
      for (int k = 0; k < 3; k++) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
